// File: rtl/comment_strip.sv
// Overwrites C comments in an ASCII stream with FILL, with a fixed two-cycle latency.
// Optional WS_NORM_EN: code bytes that are tab, LF or CR are emitted as a space.
module comment_strip #(
    parameter logic [7:0] FILL = 8'h20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in,
    output logic [7:0] out,
    output logic       in_comment
);

    localparam logic [7:0] SLASH_CH = 8'h2F;
    localparam logic [7:0] STAR_CH  = 8'h2A;
    localparam logic [7:0] NL_CH    = 8'h0A;

    typedef enum logic [2:0] {
        CODE,
        SLASH,
        LINE,
        BLOCK,
        STAR
    } state_t;

    state_t     r_state;
    logic [7:0] r_hold;
    logic       r_blank;

    state_t     w_nextState;
    logic       w_nextBlank;
    logic       w_kill;
    logic [7:0] w_codeByte;

    // The held byte is only blanked retroactively when it is the '/' that opens a comment.
    always_comb begin
        w_kill      = (r_state == SLASH) && ((in == SLASH_CH) || (in == STAR_CH));
        w_nextState = r_state;
        w_nextBlank = 1'b0;
        case (r_state)
            CODE: begin
                if (in == SLASH_CH) begin
                    w_nextState = SLASH;
                end
            end
            SLASH: begin
                if (in == SLASH_CH) begin
                    w_nextState = LINE;
                    w_nextBlank = 1'b1;
                end else if (in == STAR_CH) begin
                    w_nextState = BLOCK;
                    w_nextBlank = 1'b1;
                end else begin
                    w_nextState = CODE;
                end
            end
            LINE: begin
                if (in == NL_CH) begin
                    w_nextState = CODE;
                end else begin
                    w_nextBlank = 1'b1;
                end
            end
            BLOCK: begin
                w_nextBlank = 1'b1;
                if (in == STAR_CH) begin
                    w_nextState = STAR;
                end
            end
            STAR: begin
                w_nextBlank = 1'b1;
                if (in == SLASH_CH) begin
                    w_nextState = CODE;
                end else if (in == STAR_CH) begin
                    w_nextState = STAR;
                end else begin
                    w_nextState = BLOCK;
                end
            end
            default: begin
                w_nextState = CODE;
            end
        endcase

        w_codeByte = r_hold;
`ifdef WS_NORM_EN
        if ((r_hold == 8'h09) || (r_hold == 8'h0A) || (r_hold == 8'h0D)) begin
            w_codeByte = 8'h20;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= CODE;
            r_hold     <= FILL;
            r_blank    <= 1'b0;
            out        <= FILL;
            in_comment <= 1'b0;
        end else begin
            out        <= (r_blank || w_kill) ? FILL : w_codeByte;
            in_comment <= r_blank || w_kill;
            r_hold     <= in;
            r_blank    <= w_nextBlank;
            r_state    <= w_nextState;
        end
    end

endmodule

// File: doc/comment_strip.md
Name: comment_strip

Overview:
- Character-stream pre-filter placed directly upstream of the int-declaration checker.
- Accepts one 8-bit ASCII character per clock.
- Emits one character per clock with C comments (`//…` to end of line, `/*…*/`) overwritten by a fill character, so stream length and timing are preserved.
- The downstream checker then sees comments as whitespace.

Parameters:
- FILL, 8'h20, replacement character emitted for every comment byte, delimiters included.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- in  input  8  ASCII character, one per cycle, always valid.
- out  output  8  filtered character, registered.
- in_comment  output  1  registered; high when the current out byte was replaced by FILL.

Behaviour:
- Reset:
  - state=CODE, hold register h=FILL, blank bit b=0, out=FILL, in_comment=0.
  - Reset takes priority over everything and aborts any comment in progress.
  - The first post-reset character is treated as code.
- Latency:
  - A character presented during cycle t is sampled at edge t, held in h, and drives out/in_comment after edge t+1.
  - Fixed 2-cycle latency, no stalls, no drops. One cycle of lookahead resolves a leading '/'.
- Per edge, with S = current state and c = in:
  - kill = (S==SLASH) && (c=="/" || c=="*").
  - out <= (b || kill) ? FILL : h.
  - in_comment <= b || kill.
  - h <= c.
  - b <= blank(S,c).
  - S <= next(S,c).
- States and transitions (blank(S,c) shown in brackets):
  - CODE: c=="/" -> SLASH [0]; else CODE [0].
  - SLASH:
    - c=="/" -> LINE [1], and the held '/' is killed.
    - c=="*" -> BLOCK [1], and the held '/' is killed.
    - else -> CODE [0]; the held '/' passes unchanged.
  - LINE: c==8'h0A -> CODE [0], newline passes unchanged; else LINE [1].
  - BLOCK: c=="*" -> STAR [1]; else BLOCK [1].
  - STAR: c=="/" -> CODE [1]; c=="*" -> STAR [1]; else BLOCK [1].
- Boundary rules:
  - "/*/" does not close a block; the closing '/' needs a preceding '*' inside the block.
  - "/**/" is a complete, empty comment.
  - "//" inside a block and "/*" inside a line comment have no effect.
  - A lone '/' followed by any non-'/' non-'*' character (including space) is code, e.g. "a/b" passes unchanged.
  - A '/' arriving in SLASH starts a line comment; "///" is entirely a comment.
  - Unterminated comments persist indefinitely until the terminator or reset; no error output.
  - Byte value 8'h00 carries no special meaning; it is classified like any other non-special character.
  - Only 8'h0A ends a line comment; 8'h0D is an ordinary comment byte.

Optional Feature:
- Macro WS_NORM_EN.
  - Defined: any code byte equal to 8'h09, 8'h0A or 8'h0D is emitted as 8'h20, with in_comment=0. This covers the newline that ends a line comment. Comment detection is unchanged because it operates on in, not out.
  - Undefined: those bytes pass unchanged.

Test Plan:
- Reset held 2 cycles, then "int a;" fed one char per cycle -> after 2-cycle latency out = 'i','n','t',' ','a',';' exactly, in_comment=0 throughout; out=8'h20 during reset.
- "a/*x*/b" -> out = 'a', then 5 x 8'h20 with in_comment=1, then 'b'.
- "x//yz" + 8'h0A + "q" -> out = 'x', then 4 x 8'h20 with in_comment=1, then 8'h0A (8'h20 with WS_NORM_EN), then 'q'.
- "a/b/ c" -> output identical to input, in_comment never asserted; the '/' bytes appear one cycle after the following char is sampled.
- "/*/ */k" and "/**/k" -> every byte before 'k' is FILL; 'k' passes.
- reset asserted for 1 cycle while in BLOCK after "/*ab", then "int" -> out=FILL on the cycle after reset, then 'i','n','t' with in_comment=0.
